bram_delay_ctrl: RTL and testbench
==================================

Name: bram_delay_ctrl

Overview:
Sequencer for the 4-bit x 8-entry dual-port RAM used as a circular per-channel delay line in the beamformer. Accepts a sample stream and writes each sample at a rotating write pointer. Issues the matching read of the sample written DELAY samples earlier, and presents the delayed sample with a valid strobe. Sits between the channel sample source and the summing stage, and owns all DPRAM control (data, addresses, rden, wren).

Parameters:
DATA_W, 4, sample width (matches DPRAM data/q).
ADDR_W, 3, DPRAM address width; DEPTH = 2**ADDR_W = 8.
RD_LAT, 1, DPRAM read latency in clocks from registered rden/rdaddress to valid q.

Ports:
clock  in  1  single system clock, rising edge.
rst  in  1  asynchronous reset, active-low: 0 = reset.
start  in  1  IDLE->FILL request.
stop  in  1  abort to IDLE.
cfg_load  in  1  load cfg_delay (accepted in IDLE only).
cfg_delay  in  ADDR_W  requested delay in samples.
cfg_err  out  1  one-cycle pulse on rejected or clamped config.
in_valid  in  1  sample strobe.
in_data  in  DATA_W  sample.
out_valid  out  1  delayed sample strobe.
out_data  out  DATA_W  delayed sample (= ram_q).
busy  out  1  high in FILL or RUN.
ram_data  out  DATA_W  to DPRAM data.
ram_wraddress  out  ADDR_W  to DPRAM wraddress.
ram_wren  out  1  to DPRAM wren.
ram_rdaddress  out  ADDR_W  to DPRAM rdaddress.
ram_rden  out  1  to DPRAM rden.
ram_q  in  DATA_W  from DPRAM q.

Behaviour:
- Reset (rst=0, async): state=IDLE, delay_reg=1, wr_ptr=0, fill_cnt=0, all outputs 0 (ram_* buses 0, out_valid 0, busy 0, cfg_err 0). Output pipeline is flushed.
- States:
  - IDLE: in_valid is ignored.
  - FILL: writes only.
  - RUN: writes and reads.
- Config: cfg_load in IDLE latches delay_reg <= cfg_delay. If cfg_delay==0, it latches 1 and pulses cfg_err. cfg_load in FILL/RUN is ignored, delay_reg is unchanged, and cfg_err pulses.
- IDLE->FILL: on start. fill_cnt=0, wr_ptr=0. cfg_load and start in the same cycle: the config is applied first, then FILL is entered.
- FILL, in_valid sampled at edge k:
  - cycle k+1: ram_wren=1, ram_wraddress=wr_ptr, ram_data=in_data; wr_ptr++ mod DEPTH; fill_cnt++.
  - When fill_cnt==delay_reg-1 at the sampled write, the next state is RUN.
- RUN, in_valid sampled at edge k:
  - cycle k+1: write as in FILL, plus ram_rden=1, ram_rdaddress=(wr_ptr-delay_reg) mod DEPTH using the pre-increment wr_ptr.
  - out_valid=1 and out_data=ram_q in cycle k+1+RD_LAT.
  - Latency from in_valid to out_valid is 1+RD_LAT clocks. Back-to-back in_valid gives back-to-back out_valid.
- ram_wren and ram_rden are single-cycle registered pulses, 0 in cycles with no sample. Address and data buses hold their last value when idle.
- Write and read addresses never collide, since delay_reg>=1. Maximum delay is DEPTH-1=7.
- wr_ptr wraps 7->0, and the read address wraps modulo DEPTH.
- stop in FILL/RUN: next state IDLE. wr_ptr and fill_cnt clear, and no new RAM access is issued. A read already issued still produces its out_valid (the pipeline drains). stop has priority over in_valid in the same cycle (that sample is dropped). stop in IDLE has no effect. start outside IDLE is ignored.
- busy = (state!=IDLE), registered.
- Async reset mid-RUN: immediate return to reset values. A pending out_valid is killed.

Optional Feature:
BRAM_DELAY_CTRL_STATUS_EN:
- Defined: adds output port out_count [15:0]. It increments on every out_valid, saturates at 16'hFFFF, clears on reset and on IDLE->FILL, and holds during IDLE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset during RUN with out_valid pending -> all outputs 0 immediately, no out_valid after rst releases.
- cfg_delay=3, start, samples 1,2,3,4,5,6 on consecutive cycles:
  - wren at addresses 0..5;
  - first rden at sample 4 with rdaddress 0;
  - out_data 1,2,3 with out_valid in cycles s4+2, s5+2, s6+2.
- cfg_delay=7, stream 20 samples 0..F,0..3:
  - write address wraps 7->0;
  - out_data equals input delayed by 7 samples;
  - rdaddress = wraddress-7 mod 8 every read.
- cfg_load with cfg_delay=0 in IDLE -> cfg_err pulse, effective delay 1; cfg_load during RUN -> cfg_err pulse, delay unchanged.
- Gapped input (in_valid every 3rd cycle, delay 2) -> no RAM strobes in gap cycles, and out_valid spacing mirrors the input spacing.
- stop asserted together with in_valid in RUN after an outstanding read -> that sample is not written, the prior read's out_valid still appears, and the block returns to IDLE with busy=0.

Source files
------------

// File: rtl/bram_delay_ctrl_if.sv
// Stream, config and DPRAM control bundle for bram_delay_ctrl.
// Optional out_count exists when BRAM_DELAY_CTRL_STATUS_EN is defined.
interface bram_delay_ctrl_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
);
    logic              start;
    logic              stop;
    logic              cfg_load;
    logic [ADDR_W-1:0] cfg_delay;
    logic              cfg_err;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] ram_wraddress;
    logic              ram_wren;
    logic [ADDR_W-1:0] ram_rdaddress;
    logic              ram_rden;
    logic [DATA_W-1:0] ram_q;
`ifdef BRAM_DELAY_CTRL_STATUS_EN
    logic [15:0]       out_count;
`endif

    modport master (
        output start, stop, cfg_load, cfg_delay, in_valid, in_data, ram_q,
        input  cfg_err, out_valid, out_data, busy,
        input  ram_data, ram_wraddress, ram_wren, ram_rdaddress, ram_rden
`ifdef BRAM_DELAY_CTRL_STATUS_EN
        , input out_count
`endif
    );

    modport slave (
        input  start, stop, cfg_load, cfg_delay, in_valid, in_data, ram_q,
        output cfg_err, out_valid, out_data, busy,
        output ram_data, ram_wraddress, ram_wren, ram_rdaddress, ram_rden
`ifdef BRAM_DELAY_CTRL_STATUS_EN
        , output out_count
`endif
    );
endinterface

// File: rtl/bram_delay_ctrl.sv
// Circular-buffer delay line sequencer driving a dual-port RAM.
// Define BRAM_DELAY_CTRL_STATUS_EN to add the saturating out_count port.
//
//   state  | meaning
//   S_IDLE | stopped, samples ignored, config accepted
//   S_FILL | writing first delay_q samples, no reads yet
//   S_RUN  | each sample written and the one delay_q earlier read back
module bram_delay_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              rst,
    bram_delay_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] delay_q, delay_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
    logic              cfg_err_q, cfg_err_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic [ADDR_W-1:0] ram_wraddress_q, ram_wraddress_d;
    logic [ADDR_W-1:0] ram_rdaddress_q, ram_rdaddress_d;
    logic              ram_wren_q, ram_wren_d;
    logic              ram_rden_q, ram_rden_d;
    logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;

    always_comb begin
        state_d         = state_q;
        delay_d         = delay_q;
        wr_ptr_d        = wr_ptr_q;
        fill_cnt_d      = fill_cnt_q;
        cfg_err_d       = 1'b0;
        ram_data_d      = ram_data_q;
        ram_wraddress_d = ram_wraddress_q;
        ram_rdaddress_d = ram_rdaddress_q;
        ram_wren_d      = 1'b0;
        ram_rden_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Config lands before the start check so both can share a cycle.
                if (bus.cfg_load) begin
                    if (bus.cfg_delay == '0) begin
                        delay_d   = ADDR_W'(1);
                        cfg_err_d = 1'b1;
                    end else begin
                        delay_d = bus.cfg_delay;
                    end
                end
                if (bus.start) begin
                    state_d    = S_FILL;
                    wr_ptr_d   = '0;
                    fill_cnt_d = '0;
                end
            end
            S_FILL, S_RUN: begin
                cfg_err_d = bus.cfg_load;
                if (bus.stop) begin
                    state_d    = S_IDLE;
                    wr_ptr_d   = '0;
                    fill_cnt_d = '0;
                end else if (bus.in_valid) begin
                    ram_wren_d      = 1'b1;
                    ram_wraddress_d = wr_ptr_q;
                    ram_data_d      = bus.in_data;
                    wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
                    if (state_q == S_RUN) begin
                        ram_rden_d      = 1'b1;
                        ram_rdaddress_d = wr_ptr_q - delay_q;
                    end else begin
                        fill_cnt_d = fill_cnt_q + ADDR_W'(1);
                        if (fill_cnt_q == delay_q - ADDR_W'(1))
                            state_d = S_RUN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        // Read strobe ages alongside the RAM's own read latency.
        rd_pipe_d[0] = ram_rden_q;
        for (int i = 1; i < RD_LAT; i++)
            rd_pipe_d[i] = rd_pipe_q[i-1];
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            delay_q         <= ADDR_W'(1);
            wr_ptr_q        <= '0;
            fill_cnt_q      <= '0;
            cfg_err_q       <= 1'b0;
            busy_q          <= 1'b0;
            ram_data_q      <= '0;
            ram_wraddress_q <= '0;
            ram_rdaddress_q <= '0;
            ram_wren_q      <= 1'b0;
            ram_rden_q      <= 1'b0;
            rd_pipe_q       <= '0;
        end else begin
            state_q         <= state_d;
            delay_q         <= delay_d;
            wr_ptr_q        <= wr_ptr_d;
            fill_cnt_q      <= fill_cnt_d;
            cfg_err_q       <= cfg_err_d;
            busy_q          <= busy_d;
            ram_data_q      <= ram_data_d;
            ram_wraddress_q <= ram_wraddress_d;
            ram_rdaddress_q <= ram_rdaddress_d;
            ram_wren_q      <= ram_wren_d;
            ram_rden_q      <= ram_rden_d;
            rd_pipe_q       <= rd_pipe_d;
        end
    end

    logic out_valid;
    assign out_valid = rd_pipe_q[RD_LAT-1];

    assign bus.out_valid     = out_valid;
    assign bus.out_data      = out_valid ? bus.ram_q : '0;
    assign bus.cfg_err       = cfg_err_q;
    assign bus.busy          = busy_q;
    assign bus.ram_data      = ram_data_q;
    assign bus.ram_wraddress = ram_wraddress_q;
    assign bus.ram_rdaddress = ram_rdaddress_q;
    assign bus.ram_wren      = ram_wren_q;
    assign bus.ram_rden      = ram_rden_q;

`ifdef BRAM_DELAY_CTRL_STATUS_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (state_q == S_IDLE && bus.start)
            count_d = '0;
        else if (out_valid && count_q != 16'hFFFF)
            count_d = count_q + 16'd1;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

    assign bus.out_count = count_q;
`endif
endmodule

// File: tb/tb_bram_delay_ctrl.sv
// Self-checking bench: sample-index reference model plus a behavioural DPRAM.
module tb_bram_delay_ctrl;
    localparam int N = 4096;

    logic clock = 1'b0;
    logic rst   = 1'b0;
    always #5 clock = ~clock;

    bram_delay_ctrl_if bus ();
    bram_delay_ctrl dut (.clock(clock), .rst(rst), .bus(bus));

    logic [3:0] mem [8];
    always @(posedge clock) begin
        if (bus.ram_wren) mem[bus.ram_wraddress] <= bus.ram_data;
        if (bus.ram_rden) bus.ram_q <= mem[bus.ram_rdaddress];
    end

    // Expected outputs per cycle, filled from the sample index of each input.
    logic       e_wren [N];
    logic       e_rden [N];
    logic       e_ov   [N];
    logic       e_err  [N];
    logic       e_busy [N];
    logic [2:0] e_wa   [N];
    logic [2:0] e_ra   [N];
    logic [3:0] e_wd   [N];
    logic [3:0] e_od   [N];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    bit         act;
    int         n;
    int         dly;
    logic [3:0] hist [$];
    logic [2:0] lwa, lra;
    logic [3:0] lwd;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_now();
        chk("ram_wren",      16'(bus.ram_wren),      16'(e_wren[cyc]));
        chk("ram_rden",      16'(bus.ram_rden),      16'(e_rden[cyc]));
        chk("out_valid",     16'(bus.out_valid),     16'(e_ov[cyc]));
        chk("busy",          16'(bus.busy),          16'(e_busy[cyc]));
        chk("cfg_err",       16'(bus.cfg_err),       16'(e_err[cyc]));
        chk("ram_wraddress", 16'(bus.ram_wraddress), 16'(e_wa[cyc]));
        chk("ram_data",      16'(bus.ram_data),      16'(e_wd[cyc]));
        chk("ram_rdaddress", 16'(bus.ram_rdaddress), 16'(e_ra[cyc]));
        if (e_ov[cyc]) chk("out_data", 16'(bus.out_data), 16'(e_od[cyc]));
    endtask

    task automatic clear_from(input int c);
        for (int i = c; i < c + 5; i++) begin
            e_wren[i] = 1'b0; e_rden[i] = 1'b0; e_ov[i] = 1'b0;
            e_err[i]  = 1'b0; e_busy[i] = 1'b0;
            e_wa[i] = '0; e_ra[i] = '0; e_wd[i] = '0; e_od[i] = '0;
        end
    endtask

    task automatic step(input logic st, input logic sp, input logic ld, input logic [2:0] ldv,
                        input logic v, input logic [3:0] d);
        int nx;
        bus.start = st; bus.stop = sp; bus.cfg_load = ld; bus.cfg_delay = ldv;
        bus.in_valid = v; bus.in_data = d;
        nx = cyc + 1;
        e_wren[nx] = 1'b0; e_rden[nx] = 1'b0; e_err[nx] = 1'b0; e_ov[cyc+2] = 1'b0;
        if (!act) begin
            if (ld) begin
                if (ldv == 3'd0) begin dly = 1; e_err[nx] = 1'b1; end
                else dly = int'(ldv);
            end
            if (st) begin act = 1'b1; n = 0; hist.delete(); end
        end else begin
            if (ld) e_err[nx] = 1'b1;
            if (sp) act = 1'b0;
            else if (v) begin
                e_wren[nx] = 1'b1;
                lwa = 3'(n % 8);
                lwd = d;
                if (n >= dly) begin
                    e_rden[nx] = 1'b1;
                    lra = 3'((n - dly) % 8);
                    e_ov[cyc+2] = 1'b1;
                    e_od[cyc+2] = hist[n - dly];
                end
                hist.push_back(d);
                n++;
            end
        end
        e_wa[nx] = lwa; e_wd[nx] = lwd; e_ra[nx] = lra;
        e_busy[nx] = act;
        @(posedge clock); #1;
        cyc++;
        check_now();
    endtask

    task automatic idle();                  step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0); endtask
    task automatic sample(input logic [3:0] d); step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, d); endtask
    task automatic load(input logic [2:0] v);   step(1'b0, 1'b0, 1'b1, v, 1'b0, 4'd0); endtask
    task automatic go();                    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0); endtask
    task automatic halt();                  step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0); endtask

    task automatic model_reset();
        act = 1'b0; n = 0; dly = 1; hist.delete();
        lwa = '0; lra = '0; lwd = '0;
    endtask

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.cfg_load = 1'b0; bus.cfg_delay = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        model_reset();
        clear_from(0);
        for (int i = 5; i < N; i++) begin
            e_ov[i] = 1'b0; e_wren[i] = 1'b0; e_rden[i] = 1'b0;
        end
        #1;
        check_now();
        repeat (2) begin @(posedge clock); #1; cyc++; check_now(); end
        rst = 1'b1;

        // In-IDLE sample and stop are ignored; delay 3 with samples 1..6.
        sample(4'hA);
        halt();
        load(3'd3);
        go();
        for (int i = 1; i <= 6; i++) sample(4'(i));
        repeat (3) idle();
        halt();
        idle();

        // Delay 7, 20 samples, pointers wrap.
        step(1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 4'd0);
        for (int i = 0; i < 20; i++) sample(4'(i % 16));
        repeat (3) idle();
        halt();
        idle();

        // Zero delay clamps to 1; config during RUN is rejected.
        load(3'd0);
        go();
        for (int i = 0; i < 4; i++) sample(4'($urandom_range(0, 15)));
        step(1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 4; i++) sample(4'($urandom_range(0, 15)));
        repeat (3) idle();
        halt();
        idle();

        // Gapped input, delay 2; a stray start mid-run is ignored.
        load(3'd2);
        go();
        for (int i = 0; i < 8; i++) begin
            sample(4'($urandom_range(0, 15)));
            if (i == 4) step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0); else idle();
            idle();
        end
        halt();
        idle();

        // stop together with a sample right after a read was issued.
        load(3'd2);
        go();
        for (int i = 0; i < 3; i++) sample(4'($urandom_range(0, 15)));
        step(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 4'hF);
        repeat (3) idle();

        // Random delays and random valid density.
        for (int r = 0; r < 3; r++) begin
            load(3'($urandom_range(1, 7)));
            go();
            for (int i = 0; i < 50; i++) begin
                if ($urandom_range(0, 99) < 5)
                    step(1'b0, 1'b0, 1'b1, 3'($urandom_range(0, 7)), 1'b1, 4'($urandom_range(0, 15)));
                else if ($urandom_range(0, 99) < 60)
                    sample(4'($urandom_range(0, 15)));
                else
                    idle();
            end
            halt();
            repeat (2) idle();
        end

        // Async reset mid-RUN with a read outstanding.
        load(3'd2);
        go();
        for (int i = 0; i < 4; i++) sample(4'($urandom_range(0, 15)));
        #3 rst = 1'b0;
        #1;
        chk("rst_wren",      16'(bus.ram_wren),      16'h0);
        chk("rst_rden",      16'(bus.ram_rden),      16'h0);
        chk("rst_out_valid", 16'(bus.out_valid),     16'h0);
        chk("rst_out_data",  16'(bus.out_data),      16'h0);
        chk("rst_busy",      16'(bus.busy),          16'h0);
        chk("rst_wraddress", 16'(bus.ram_wraddress), 16'h0);
        chk("rst_rdaddress", 16'(bus.ram_rdaddress), 16'h0);
        chk("rst_ram_data",  16'(bus.ram_data),      16'h0);
        model_reset();
        clear_from(cyc);
        repeat (2) begin @(posedge clock); #1; cyc++; check_now(); end
        rst = 1'b1;
        repeat (2) idle();
        go();
        for (int i = 0; i < 4; i++) sample(4'($urandom_range(0, 15)));
        repeat (3) idle();
        halt();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
